serial_add_ctrl: RTL

Bit-serial add/subtract engine that time-shares a single `fulladder` bit cell across all operand bits, LSB first, one bit per clock. It holds a carry flip-flop, operand and result shift registers, a bit counter, and a start/done handshake FSM. It sits beside the combinational adder datapath as the area-minimal alternative for wide operands where latency is acceptable.

---
 rtl/serial_add_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial add/subtract engine. One full-adder bit cell is time-shared over
// all operand bits, LSB first, one bit per clock. A start/done handshake FSM
// (IDLE -> RUN -> DONE -> IDLE) sequences the operation.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..64)
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   operation request, sampled only in IDLE
//   sub    in   0 = a+b, 1 = a-b, latched with the operands
//   a      in   operand A, latched on an accepted start
//   b      in   operand B, latched on an accepted start
//   busy   out  high while the engine is in RUN
//   done   out  one-cycle pulse, result valid
//   sum    out  result modulo 2^WIDTH
//   cout   out  carry out of the MSB (for subtract, 1 = no borrow)
//   ovf    out  signed overflow
// ---------------------------------------------------------------------------

// Single-bit full adder cell shared across all bit positions.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             sub_q;
    logic             carry_q;
    logic             cmsb_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             run_step;
    logic             last_bit;
    logic             busy_d;
    logic             done_d;
    logic             fa_s;
    logic             fa_c;

    // Subtraction is a + ~b + 1: B is inverted bit by bit and the +1 comes
    // from preloading the carry with sub on accept.
    fulladder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0] ^ sub_q),
        .cin (carry_q),
        .s   (fa_s),
        .c   (fa_c)
    );

    assign last_bit = (cnt == LAST_CNT);

    // State register; reset has priority over any start request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Start is only looked at in IDLE, so a request in RUN
    // or DONE is dropped rather than queued.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)    next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:                  next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // Output decode. busy/done are derived from the next state and then
    // registered so they carry no combinational path from the inputs.
    always_comb begin
        accept   = (state == IDLE) && start;
        run_step = (state == RUN);
        busy_d   = (next_state == RUN);
        done_d   = (next_state == DONE);
    end

    // Handshake output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Datapath: operands are loaded on accept and shifted right on every RUN
    // edge; each new sum bit enters at the MSB, so after WIDTH edges bit 0
    // has arrived at the LSB. Nothing changes in IDLE or DONE, which keeps
    // the result stable until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            sum_q   <= '0;
            cnt     <= '0;
            sub_q   <= sub;
            carry_q <= sub;
            cmsb_q  <= 1'b0;
        end else if (run_step) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
            carry_q <= fa_c;
            cnt     <= cnt + 1'b1;
            // The carry entering the MSB cell is needed for signed overflow.
            if (last_bit) begin
                cmsb_q <= carry_q;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = carry_q;
    assign ovf  = cmsb_q ^ carry_q;

endmodule
